// File: rtl/barrel_rotator_left_pipe.sv
// Pipelined barrel rotator: one registered mux stage per amount bit, valid/ready flow control.
// Define BARREL_ROTATE_DIR_EN to add in_dir_right, a per-word right-rotate select carried with each word.
module barrel_rotator_left_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amount,
`ifdef BARREL_ROTATE_DIR_EN
    input  logic                     in_dir_right,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
);
    localparam int STAGES = $clog2(WIDTH);

    // Each stage holds its word already rotated by its own power of two;
    // r_amt keeps only the amount bits still to be applied downstream.
    logic              r_valid [STAGES];
    logic [WIDTH-1:0]  r_data  [STAGES];
    logic [STAGES-1:0] r_amt   [STAGES];
    logic              r_dir   [STAGES];
    logic [STAGES-1:0] w_adv;
    logic              w_in_dir;

`ifdef BARREL_ROTATE_DIR_EN
    assign w_in_dir = in_dir_right;
`else
    assign w_in_dir = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] rot_stage(input logic [WIDTH-1:0] d, input int k,
                                                   input logic en, input logic right);
        int sh;
        sh = 1 << k;
        if (!en)
            return d;
        if (right)
            return (d >> sh) | (d << (WIDTH - sh));
        return (d << sh) | (d >> (WIDTH - sh));
    endfunction

    // Advance chain: a stage may load when it is empty or its successor advances.
    always_comb begin
        logic w_chain;
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        w_adv   = '0;
        w_chain = !r_valid[STAGES-1] || out_ready;
        w_adv[STAGES-1] = w_chain;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_chain  = !r_valid[k] || w_chain;
            w_adv[k] = w_chain;
        end
    end

    // NOTE: state updates use <= so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: data/amount registers are cleared too, so out_data reads 0 straight out of reset.
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_amt[k]   <= '0;
                r_dir[k]   <= 1'b0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                r_data[0]  <= rot_stage(in_data, 0, in_amount[0], w_in_dir);
                r_amt[0]   <= in_amount >> 1;
                r_dir[0]   <= w_in_dir;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= rot_stage(r_data[k-1], k, r_amt[k-1][0], r_dir[k-1]);
                    r_amt[k]   <= r_amt[k-1] >> 1;
                    r_dir[k]   <= r_dir[k-1];
                end
            end
        end
    end

    assign in_ready  = w_adv[0] && !reset;
    assign out_valid = r_valid[STAGES-1] && !reset;
    assign out_data  = reset ? '0 : r_data[STAGES-1];

endmodule

// File: tb/tb_barrel_rotator_left_pipe.sv
// Directed bench for barrel_rotator_left_pipe (WIDTH=8): latency, streaming, backpressure, reset, inverse.
module tb_barrel_rotator_left_pipe;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amount;
    logic       in_dir_right;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    barrel_rotator_left_pipe #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_amount    (in_amount),
`ifdef BARREL_ROTATE_DIR_EN
        .in_dir_right (in_dir_right),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // Reference right-rotate, standing in for the companion right-rotate stage.
    function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] t;
        t = {x, x} >> n;
        return t[7:0];
    endfunction

    // One clock cycle: drive at posedge+1, observe at negedge, return at next posedge+1.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] a, input logic rdy,
                         output logic acc, output logic got, output logic [7:0] word);
        in_valid  = v;
        in_data   = d;
        in_amount = a;
        out_ready = rdy;
        @(negedge clk);
        acc  = in_valid && in_ready;
        got  = out_valid && out_ready;
        word = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        in_amount    = 3'd0;
        in_dir_right = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_latency();
        logic acc, got;
        logic [7:0] w, res;
        int lat;
        lat = -1;
        res = 8'h00;
        cycle(1'b1, 8'h81, 3'd1, 1'b1, acc, got, w);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL latency_accept: got %b want 1", acc); end
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b1, acc, got, w);
            if (got) begin lat = c; res = w; end
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL latency_cycles: got %0d want 3", lat); end
        checks++;
        if (res !== 8'h03) begin failures++; $display("FAIL latency_data: got %h want 03", res); end
    endtask

    task automatic test_directed();
        logic acc, got;
        logic [7:0] w;
        logic [7:0] vd[3]  = '{8'hB4, 8'h5A, 8'h01};
        logic [2:0] va[3]  = '{3'd3, 3'd0, 3'd7};
        logic [7:0] vexp[3] = '{8'hA5, 8'h5A, 8'h80};
        int nin, nout;
        nin  = 0;
        nout = 0;
        for (int c = 0; c < 15 && nout < 3; c++) begin
            cycle(nin < 3, vd[nin % 3], va[nin % 3], 1'b1, acc, got, w);
            if (acc) nin++;
            if (got) begin
                checks++;
                if (w !== vexp[nout]) begin
                    failures++;
                    $display("FAIL directed_word%0d: got %h want %h", nout, w, vexp[nout]);
                end
                nout++;
            end
        end
        checks++;
        if (nout != 3) begin failures++; $display("FAIL directed_count: got %0d want 3", nout); end
    endtask

    task automatic test_back_to_back();
        logic acc, got;
        logic [7:0] w, e;
        logic [7:0] q[$];
        int nin, nout, first_out, last_out;
        nin = 0; nout = 0; first_out = -1; last_out = -1;
        for (int c = 0; c < 40 && nout < 16; c++) begin
            cycle(nin < 16, 8'(nin * 17), 3'(nin % 8), 1'b1, acc, got, w);
            if (acc) begin q.push_back(rotl(8'(nin * 17), 3'(nin % 8))); nin++; end
            if (got) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                e = q.pop_front();
                checks++;
                if (w !== e) begin failures++; $display("FAIL stream_word%0d: got %h want %h", nout, w, e); end
                nout++;
            end
        end
        checks++;
        if (first_out != 3) begin failures++; $display("FAIL stream_first_cycle: got %0d want 3", first_out); end
        checks++;
        if (last_out != 18) begin failures++; $display("FAIL stream_last_cycle: got %0d want 18", last_out); end
        checks++;
        if (nout != 16) begin failures++; $display("FAIL stream_count: got %0d want 16", nout); end
    endtask

    task automatic test_backpressure();
        logic acc, got, rdy;
        logic [7:0] w, e;
        logic [7:0] q[$];
        logic [7:0] wd[4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [2:0] wa[4] = '{3'd2, 3'd5, 3'd7, 3'd4};
        logic       pat[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int nin, nout;
        nin = 0; nout = 0;
        for (int c = 0; c < 30 && nout < 4; c++) begin
            rdy = 1'b1;
            if (c < 8) rdy = pat[c];
            cycle(nin < 4, wd[nin % 4], wa[nin % 4], rdy, acc, got, w);
            if (acc) begin q.push_back(rotl(wd[nin], wa[nin])); nin++; end
            if (got) begin
                e = q.pop_front();
                checks++;
                if (w !== e) begin failures++; $display("FAIL bp_word%0d: got %h want %h", nout, w, e); end
                nout++;
            end
            if (c == 3) begin
                checks++;
                if (acc !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b want 0", acc); end
                checks++;
                if (nin != 3) begin failures++; $display("FAIL bp_accepted: got %0d want 3", nin); end
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h48) begin
                    failures++;
                    $display("FAIL bp_hold_first: got v=%b d=%h want v=1 d=48", out_valid, out_data);
                end
            end
            if (c == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h86) begin
                    failures++;
                    $display("FAIL bp_hold_second: got v=%b d=%h want v=1 d=86", out_valid, out_data);
                end
            end
        end
        checks++;
        if (nout != 4 || q.size() != 0) begin
            failures++;
            $display("FAIL bp_count: got out=%0d left=%0d want out=4 left=0", nout, q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, got;
        logic [7:0] w;
        int stale;
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 8'hC3 + 8'(i), 3'(i + 1), 1'b1, acc, got, w);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin failures++; $display("FAIL midreset_out_data: got %h want 00", out_data); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready: got %b want 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready_after: got %b want 1", in_ready); end
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b1, acc, got, w);
            if (got) stale++;
        end
        checks++;
        if (stale != 0) begin failures++; $display("FAIL midreset_stale: got %0d words want 0", stale); end
    endtask

    task automatic test_inverse();
        logic acc, got;
        logic [7:0] w, e, x;
        logic [2:0] n;
        logic [7:0] q[$];
        int nin, nout;
        nin = 0; nout = 0;
        for (int c = 0; c < 2300 && nout < 2048; c++) begin
            x = 8'(nin / 8);
            n = 3'(nin % 8);
            cycle(nin < 2048, rotr(x, n), n, 1'b1, acc, got, w);
            if (acc) begin q.push_back(x); nin++; end
            if (got) begin
                e = q.pop_front();
                checks++;
                if (w !== e) begin failures++; $display("FAIL inverse_word%0d: got %h want %h", nout, w, e); end
                nout++;
            end
        end
        checks++;
        if (nout != 2048) begin failures++; $display("FAIL inverse_count: got %0d want 2048", nout); end
    endtask

`ifdef BARREL_ROTATE_DIR_EN
    task automatic test_dir_right();
        logic acc, got;
        logic [7:0] w, res;
        int seen;
        seen = 0;
        res  = 8'h00;
        in_dir_right = 1'b1;
        cycle(1'b1, 8'h81, 3'd1, 1'b1, acc, got, w);
        in_dir_right = 1'b0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            cycle(1'b0, 8'h00, 3'd0, 1'b1, acc, got, w);
            if (got) begin seen = 1; res = w; end
        end
        checks++;
        if (seen != 1 || res !== 8'hC0) begin
            failures++;
            $display("FAIL dir_right: got seen=%0d d=%h want seen=1 d=c0", seen, res);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_inverse();
`ifdef BARREL_ROTATE_DIR_EN
        test_dir_right();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
